// File: rtl/mul_acc_stage.sv
// Sequential MAC stage: sums a programmed number of unsigned products into a wide accumulator.
// Optional MUL_ACC_SATURATE_EN clamps the sum at all-ones on carry out instead of wrapping.
//
// state | meaning
// IDLE  | waiting for start; last result and overflow still visible
// ACCUM | accepting one product per cycle until the term count runs out
// HOLD  | result presented with out_valid until out_ready
module mul_acc_stage #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              overflow,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [LEN_W-1:0]   count;
    logic [ACC_W-1:0]   acc;
    logic               ovf;
    logic [ACC_W:0]     sum;
    logic               xfer;

    assign xfer = (state == ACCUM) && in_valid;
    assign sum  = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && (count == LEN_W'(1))) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
        end else if ((state == IDLE) && start) begin
            count <= len;
            acc   <= '0;
            ovf   <= 1'b0;
        end else if (xfer) begin
            count <= count - LEN_W'(1);
            ovf   <= ovf | sum[ACC_W];
`ifdef MUL_ACC_SATURATE_EN
            // once clamped, the sum stays pinned for the rest of the run
            if (sum[ACC_W] || ovf) begin
                acc <= {ACC_W{1'b1}};
            end else begin
                acc <= sum[ACC_W-1:0];
            end
`else
            acc   <= sum[ACC_W-1:0];
`endif
        end
    end

    assign out_acc  = acc;
    assign overflow = ovf;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mul_acc_stage.sv
// Directed bench for mul_acc_stage: default 24-bit accumulator plus an 18-bit instance for overflow.
module tb_mul_acc_stage;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_prod;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_acc;
    logic        overflow;
    logic        busy;

    logic        start_18;
    logic [7:0]  len_18;
    logic        in_valid_18;
    logic        in_ready_18;
    logic [15:0] in_prod_18;
    logic        out_valid_18;
    logic        out_ready_18;
    logic [17:0] out_acc_18;
    logic        overflow_18;
    logic        busy_18;

    int checks;
    int failures;

    mul_acc_stage u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .overflow  (overflow),
        .busy      (busy)
    );

    mul_acc_stage #(.ACC_W(18)) u_dut_18 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_18),
        .len       (len_18),
        .in_valid  (in_valid_18),
        .in_ready  (in_ready_18),
        .in_prod   (in_prod_18),
        .out_valid (out_valid_18),
        .out_ready (out_ready_18),
        .out_acc   (out_acc_18),
        .overflow  (overflow_18),
        .busy      (busy_18)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] prod, input int gap);
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) tick();
        in_valid = 1'b1;
        in_prod  = prod;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] n);
        start = 1'b1;
        len   = n;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [17:0] exp18;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        start = 1'b0; len = '0; in_valid = 1'b0; in_prod = '0; out_ready = 1'b0;
        start_18 = 1'b0; len_18 = '0; in_valid_18 = 1'b0; in_prod_18 = '0; out_ready_18 = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_acc", out_acc, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        // three full-scale products back-to-back
        do_start(8'd3);
        chk("t1_in_ready", in_ready, 1);
        chk("t1_busy", busy, 1);
        in_valid = 1'b1;
        in_prod  = 16'd65025;
        tick();
        tick();
        chk("t1_not_yet_valid", out_valid, 0);
        tick();
        in_valid = 1'b0;
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_acc", out_acc, 195075);
        chk("t1_overflow", overflow, 0);
        chk("t1_in_ready_hold", in_ready, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t1_idle_valid", out_valid, 0);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_acc_kept", out_acc, 195075);

        // gapped input and a stalled consumer
        do_start(8'd4);
        send(16'd10, 2);
        send(16'd20, 2);
        send(16'd30, 2);
        send(16'd40, 2);
        in_valid = 1'b1;
        in_prod  = 16'd999;
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", out_valid, 1);
            chk("t2_hold_acc", out_acc, 100);
            chk("t2_hold_in_ready", in_ready, 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t2_idle_valid", out_valid, 0);
        chk("t2_idle_busy", busy, 0);
        chk("t2_idle_acc", out_acc, 100);

        // zero-length run
        do_start(8'd0);
        chk("t3_out_valid", out_valid, 1);
        chk("t3_out_acc", out_acc, 0);
        chk("t3_in_ready", in_ready, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t3_idle", busy, 0);

        // start ignored in ACCUM and HOLD, in_valid ignored in IDLE
        do_start(8'd3);
        send(16'd5, 0);
        start = 1'b1;
        len   = 8'd0;
        tick();
        start = 1'b0;
        chk("t5_still_accum", busy, 1);
        send(16'd6, 0);
        chk("t5_count_kept", out_valid, 0);
        send(16'd7, 0);
        chk("t5_out_valid", out_valid, 1);
        chk("t5_out_acc", out_acc, 18);
        start = 1'b1;
        len   = 8'd2;
        tick();
        chk("t5_hold_start", out_valid, 1);
        chk("t5_hold_acc", out_acc, 18);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        chk("t5_leave_hold", busy, 0);
        tick();
        chk("t5_no_restart", busy, 0);
        in_valid = 1'b1;
        in_prod  = 16'd50;
        tick();
        chk("t5_idle_in_ready", in_ready, 0);
        chk("t5_idle_acc", out_acc, 18);
        in_valid = 1'b0;

        // asynchronous reset mid-run
        do_start(8'd4);
        send(16'd100, 0);
        send(16'd200, 0);
        chk("t6_partial", out_acc, 300);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_acc", out_acc, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_in_ready", in_ready, 0);
        chk("t6_rst_valid", out_valid, 0);
        tick();
        rst_n = 1'b1;
        tick();
        do_start(8'd1);
        send(16'd7, 0);
        chk("t6_fresh_valid", out_valid, 1);
        chk("t6_fresh_acc", out_acc, 7);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // narrow accumulator overflow
        start_18 = 1'b1;
        len_18   = 8'd5;
        tick();
        start_18 = 1'b0;
        in_valid_18 = 1'b1;
        in_prod_18  = 16'd65025;
        for (int i = 0; i < 4; i++) tick();
        chk("t4_no_ovf_yet", overflow_18, 0);
        tick();
        in_valid_18 = 1'b0;
`ifdef MUL_ACC_SATURATE_EN
        exp18 = 18'd262143;
`else
        exp18 = 18'd62981;
`endif
        chk("t4_out_valid", out_valid_18, 1);
        chk("t4_overflow", overflow_18, 1);
        chk("t4_out_acc", out_acc_18, exp18);
        out_ready_18 = 1'b1;
        tick();
        out_ready_18 = 1'b0;
        chk("t4_idle_ovf_kept", overflow_18, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
